seq_shifter: RTL and testbench

Multicycle variable-amount shifter for the lab CPU datapath. It shifts a WIDTH-bit operand by 0..2^AMT_W-1 positions, one position per clock.
- Supports rotate-right, logical-left, logical-right and arithmetic-right.
- Uses a start/busy/done handshake with the controller FSM.
- Sits beside the single-step ALU-B shifter and serves multi-bit shift instructions.

---
 rtl/seq_shifter_pkg.sv | 16 +
 rtl/seq_shifter_if.sv | 29 ++
 rtl/seq_shifter_step.sv | 37 +++
 rtl/seq_shifter.sv | 92 +++++++++
 tb/tb_seq_shifter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the multicycle shifter: operation codes and FSM states.
// Imported by the interface, the step shifter and the top.
package seq_shift_pkg;

   localparam logic [1:0] OP_ROR = 2'b00;
   localparam logic [1:0] OP_LSL = 2'b01;
   localparam logic [1:0] OP_LSR = 2'b10;
   localparam logic [1:0] OP_ASR = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// Handshake and data bundle between the controller FSM and the multicycle shifter.
// The controller side uses master; the shifter uses slave.
interface seq_shifter_if #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
);
   import seq_shift_pkg::*;

   logic             start;
   logic [1:0]       op;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;

   modport master (
      output start, op, amt, din,
      input  busy, done, result, carry, zero
   );

   modport slave (
      input  start, op, amt, din,
      output busy, done, result, carry, zero
   );

endinterface

// File: rtl/seq_shifter_step.sv
// Combinational single-position shifter: one step of ROR/LSL/LSR/ASR plus the bit
// that leaves the word (for ROR, the bit rotated into the MSB).
module shift_step
   import seq_shift_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] next,
   output logic             out_bit
);

   always_comb begin
      next    = acc;
      out_bit = 1'b0;
      case (op)
         OP_ROR: begin
            next    = {acc[0], acc[WIDTH-1:1]};
            out_bit = acc[0];
         end
         OP_LSL: begin
            next    = {acc[WIDTH-2:0], 1'b0};
            out_bit = acc[WIDTH-1];
         end
         OP_LSR: begin
            next    = {1'b0, acc[WIDTH-1:1]};
            out_bit = acc[0];
         end
         default: begin
            next    = {acc[WIDTH-1], acc[WIDTH-1:1]};
            out_bit = acc[0];
         end
      endcase
   end

endmodule

// File: rtl/seq_shifter.sv
// Multicycle variable-amount shifter: one position per clock, start/busy/done handshake.
// FSM, down-counter and accumulator live here; the per-step datapath is shift_step.
module seq_shifter
   import seq_shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic         clk,
   input  logic         reset,
   seq_shifter_if.slave bus
);

   state_t           state, nextstate;
   logic [WIDTH-1:0] acc;
   logic [1:0]       opreg;
   logic [AMT_W-1:0] cnt;
   logic             carry;
   logic [WIDTH-1:0] stepnext;
   logic             stepout;
   logic             accept;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .acc     (acc),
      .op      (opreg),
      .next    (stepnext),
      .out_bit (stepout)
   );

   // A request is only taken when not mid-shift; DONE may accept back-to-back.
   assign accept = bus.start && (state != S_SHIFT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= nextstate;
      end
   end

   always_comb begin
      nextstate = state;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               nextstate = (bus.amt != '0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            bus.busy = 1'b1;
            if (cnt == AMT_W'(1)) begin
               nextstate = S_DONE;
            end
         end
         S_DONE: begin
            bus.done = 1'b1;
            if (accept) begin
               nextstate = (bus.amt != '0) ? S_SHIFT : S_DONE;
            end else begin
               nextstate = S_IDLE;
            end
         end
         default: nextstate = S_IDLE;
      endcase
   end

   // Operands are captured on accept; the accumulator then walks one step per SHIFT cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc   <= '0;
         opreg <= OP_ROR;
         cnt   <= '0;
         carry <= 1'b0;
      end else if (accept) begin
         acc   <= bus.din;
         opreg <= bus.op;
         cnt   <= bus.amt;
         carry <= 1'b0;
      end else if (state == S_SHIFT) begin
         acc   <= stepnext;
         carry <= stepout;
         cnt   <= cnt - AMT_W'(1);
      end
   end

   assign bus.result = acc;
   assign bus.carry  = carry;
   assign bus.zero   = (acc == '0);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_seq_shifter;
   import seq_shift_pkg::*;

   localparam int W = 16;
   localparam int A = 4;

   typedef struct {
      logic [1:0]   op;
      int           amt;
      logic [W-1:0] din;
      logic [W-1:0] expResult;
      logic         expCarry;
   } vector_t;

   logic clk = 1'b0;
   logic reset;
   int   passCount = 0;
   int   checkCount = 0;

   always #5 clk = ~clk;

   seq_shifter_if #(.WIDTH(W), .AMT_W(A)) bus ();

   seq_shifter #(.WIDTH(W), .AMT_W(A)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Reference: whole-word shifts by the full amount, last bit out taken from the original operand.
   function automatic void model(input logic [1:0] op, input int amt, input logic [W-1:0] din,
                                 output logic [W-1:0] r, output logic c);
      logic [2*W-1:0] wide;
      int m;
      c = 1'b0;
      case (op)
         OP_LSL: begin
            wide = {{W{1'b0}}, din} << amt;
            r = wide[W-1:0];
            if (amt != 0) c = wide[W];
         end
         OP_LSR: begin
            r = din >> amt;
            if (amt != 0) c = din[amt-1];
         end
         OP_ASR: begin
            r = W'($signed(din) >>> amt);
            if (amt != 0) c = din[amt-1];
         end
         default: begin
            m = amt % W;
            r = (din >> m) | (din << (W - m));
            if (amt != 0) c = r[W-1];
         end
      endcase
   endfunction

   task automatic applyStimulus(input logic [1:0] op, input int amt, input logic [W-1:0] din);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.amt   = A'(amt);
      bus.din   = din;
   endtask

   task automatic checkOp(input string tag, input logic [1:0] op, input int amt, input logic [W-1:0] din,
                          input logic [W-1:0] expR, input logic expC);
      int cycles;
      int busyCycles;
      applyStimulus(op, amt, din);
      @(negedge clk);
      bus.start  = 1'b0;
      cycles     = 1;
      busyCycles = 0;
      while (bus.done !== 1'b1 && cycles < 64) begin
         if (bus.busy === 1'b1) busyCycles++;
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, " latency"}, cycles, amt + 1);
      checkOutput({tag, " busy cycles"}, busyCycles, amt);
      checkOutput({tag, " busy in done"}, bus.busy, 0);
      checkOutput({tag, " result"}, bus.result, expR);
      checkOutput({tag, " carry"}, bus.carry, expC);
      checkOutput({tag, " zero"}, bus.zero, (expR == '0));
   endtask

   initial begin
      vector_t      vecs[$];
      logic [W-1:0] r;
      logic         c;
      logic [1:0]   rop;
      int           ramt;
      logic [W-1:0] rdin;
      int           cycles;
      bit           sawDone;

      vecs.push_back('{OP_LSL, 15, 16'h0001, 16'h8000, 1'b0});
      vecs.push_back('{OP_ASR,  4, 16'h8000, 16'hF800, 1'b0});
      vecs.push_back('{OP_LSR,  4, 16'h8000, 16'h0800, 1'b0});
      vecs.push_back('{OP_ROR,  1, 16'h0001, 16'h8000, 1'b1});
      vecs.push_back('{OP_LSL,  1, 16'h8000, 16'h0000, 1'b1});
      vecs.push_back('{OP_ASR,  0, 16'h1234, 16'h1234, 1'b0});
      vecs.push_back('{OP_ROR,  4, 16'h1234, 16'h4123, 1'b0});
      vecs.push_back('{OP_ASR,  3, 16'h7FFF, 16'h0FFF, 1'b1});

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = OP_ROR;
      bus.amt   = '0;
      bus.din   = '0;
      #1;
      checkOutput("reset busy", bus.busy, 0);
      checkOutput("reset done", bus.done, 0);
      checkOutput("reset result", bus.result, 0);
      checkOutput("reset carry", bus.carry, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i])
         checkOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].amt, vecs[i].din, vecs[i].expResult, vecs[i].expCarry);

      // amt=0 completes at once; holding start in DONE takes the next request back-to-back.
      applyStimulus(OP_LSR, 0, 16'h1234);
      @(negedge clk);
      checkOutput("b2b first done", bus.done, 1);
      checkOutput("b2b first busy", bus.busy, 0);
      checkOutput("b2b first result", bus.result, 16'h1234);
      checkOutput("b2b first carry", bus.carry, 0);
      bus.op  = OP_LSL;
      bus.amt = A'(2);
      bus.din = 16'h4003;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("b2b accepted busy", bus.busy, 1);
      @(negedge clk);
      checkOutput("b2b second busy", bus.busy, 1);
      @(negedge clk);
      checkOutput("b2b second done", bus.done, 1);
      checkOutput("b2b second result", bus.result, 16'h000C);
      checkOutput("b2b second carry", bus.carry, 1);

      // A start pulse while busy must not disturb the running operation.
      applyStimulus(OP_LSR, 8, 16'hFF00);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
         bus.start = (cycles == 3);
         if (cycles == 3) begin
            bus.din = 16'h0001;
            bus.op  = OP_LSL;
            bus.amt = A'(1);
         end
      end while (bus.done !== 1'b1 && cycles < 64);
      checkOutput("ignore latency", cycles, 9);
      checkOutput("ignore result", bus.result, 16'h00FF);
      checkOutput("ignore carry", bus.carry, 0);
      @(negedge clk);
      checkOutput("ignore idle done", bus.done, 0);
      checkOutput("ignore idle busy", bus.busy, 0);

      // Asynchronous reset in the middle of a long shift aborts it with no done.
      applyStimulus(OP_LSL, 10, 16'h0001);
      repeat (4) @(negedge clk);
      bus.start = 1'b0;
      #2 reset = 1'b1;
      #1;
      checkOutput("abort busy", bus.busy, 0);
      checkOutput("abort done", bus.done, 0);
      checkOutput("abort result", bus.result, 0);
      @(negedge clk);
      reset   = 1'b0;
      sawDone = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done === 1'b1) sawDone = 1'b1;
      end
      checkOutput("abort no done", sawDone, 0);
      checkOp("after abort", OP_ASR, 5, 16'hA5A5, 16'hFD2D, 1'b0);

      for (int i = 0; i < 40; i++) begin
         rop  = 2'($urandom_range(0, 3));
         ramt = $urandom_range(0, (1 << A) - 1);
         rdin = W'($urandom);
         model(rop, ramt, rdin, r, c);
         checkOp($sformatf("rand%0d op%0d amt%0d din%0h", i, rop, ramt, rdin), rop, ramt, rdin, r, c);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
